// File: rtl/ex_muldiv.sv
// Multiply/divide unit for the EX stage: pipelined MULT/MULTU and iterative
// radix-2 restoring DIV/DIVU, with HI/LO returned together as {hi, lo}.
module ex_muldiv #(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [1:0]           op_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 flush_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 stallreq_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_mul_pipe [MUL_STAGES];
   logic [WIDTH-1:0]     r_dividend;
   logic [WIDTH-1:0]     r_divisor;
   logic [WIDTH-1:0]     r_quot;
   logic [WIDTH-1:0]     r_rem;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_ready;
   logic                 r_busy;

   logic                 w_accept;
   logic [2*WIDTH-1:0]   w_a_ext;
   logic [2*WIDTH-1:0]   w_b_ext;
   logic [2*WIDTH-1:0]   w_prod;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_rem_shift;
   logic [WIDTH:0]       w_diff;
   logic [WIDTH-1:0]     w_q_next;
   logic [WIDTH-1:0]     w_r_next;
   logic [WIDTH-1:0]     w_q_final;
   logic [WIDTH-1:0]     w_r_final;
   logic [2*WIDTH-1:0]   w_div_result;
   logic                 w_stall;

   // Operand conditioning at accept: sign-extended product and division magnitudes.
   always_comb begin
      w_accept = (r_state == S_IDLE) && start_i && !flush_i;
      // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
      w_a_ext  = {{WIDTH{~op_i[0] & opdata1_i[WIDTH-1]}}, opdata1_i};
      w_b_ext  = {{WIDTH{~op_i[0] & opdata2_i[WIDTH-1]}}, opdata2_i};
      w_prod   = w_a_ext * w_b_ext;
      w_a_neg  = ~op_i[0] & opdata1_i[WIDTH-1];
      w_b_neg  = ~op_i[0] & opdata2_i[WIDTH-1];
      w_a_mag  = w_a_neg ? (-opdata1_i) : opdata1_i;
      w_b_mag  = w_b_neg ? (-opdata2_i) : opdata2_i;
   end

   // One restoring-division step plus sign fix-up and divide-by-zero override.
   always_comb begin
      w_rem_shift = {r_rem, r_quot[WIDTH-1]};
      w_diff      = w_rem_shift - {1'b0, r_divisor};
      w_q_next    = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
      w_r_next    = w_diff[WIDTH] ? w_rem_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_q_final   = r_neg_q ? (-w_q_next) : w_q_next;
      w_r_final   = r_neg_r ? (-w_r_next) : w_r_next;
      if (r_divisor == {WIDTH{1'b0}}) begin
         w_div_result = {r_dividend, {WIDTH{1'b1}}};
      end else begin
         w_div_result = {w_r_final, w_q_final};
      end
   end

   // Stall request to pipeline control; forced low while in reset.
   always_comb begin
      w_stall = 1'b0;
      if (rst) begin
         w_stall = 1'b0;
      end else begin
         case (r_state)
            S_IDLE:  w_stall = start_i & ~flush_i;
            S_MUL:   w_stall = 1'b1;
            S_DIV:   w_stall = 1'b1;
            default: w_stall = 1'b0;
         endcase
      end
   end

   // Control FSM, operand latches, multiply pipeline and division datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= {CW{1'b0}};
         r_dividend <= {WIDTH{1'b0}};
         r_divisor  <= {WIDTH{1'b0}};
         r_quot     <= {WIDTH{1'b0}};
         r_rem      <= {WIDTH{1'b0}};
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_result   <= {(2*WIDTH){1'b0}};
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         for (int k = 0; k < MUL_STAGES; k++) begin
            r_mul_pipe[k] <= {(2*WIDTH){1'b0}};
         end
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt         <= {CW{1'b0}};
                  r_busy        <= 1'b1;
                  r_mul_pipe[0] <= w_prod;
                  r_dividend    <= opdata1_i;
                  r_divisor     <= w_b_mag;
                  r_quot        <= w_a_mag;
                  r_rem         <= {WIDTH{1'b0}};
                  r_neg_q       <= w_a_neg ^ w_b_neg;
                  r_neg_r       <= w_a_neg;
                  r_state       <= op_i[1] ? S_DIV : S_MUL;
               end
            end
            S_MUL: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  for (int k = 1; k < MUL_STAGES; k++) begin
                     r_mul_pipe[k] <= r_mul_pipe[k-1];
                  end
                  if (r_cnt == CW'(MUL_STAGES - 1)) begin
                     r_state  <= S_DONE;
                     r_ready  <= 1'b1;
                     r_result <= r_mul_pipe[MUL_STAGES-1];
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_DIV: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_quot <= w_q_next;
                  r_rem  <= w_r_next;
                  if (r_cnt == CW'(WIDTH - 1)) begin
                     r_state  <= S_DONE;
                     r_ready  <= 1'b1;
                     r_result <= w_div_result;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign result_o   = r_result;
   assign ready_o    = r_ready;
   assign busy_o     = r_busy;
   assign stallreq_o = w_stall;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH=32, MUL_STAGES=2): latency, results,
// flush, reset abort and back-to-back issue with start_i held high.
module tb_ex_muldiv;

   logic          clk;
   logic          rst;
   logic          start_i;
   logic [1:0]    op_i;
   logic [31:0]   opdata1_i;
   logic [31:0]   opdata2_i;
   logic          flush_i;
   logic [63:0]   result_o;
   logic          ready_o;
   logic          busy_o;
   logic          stallreq_o;

   int            checks;
   int            errors;
   logic [63:0]   prev;
   int            hits;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   ex_muldiv #(.WIDTH(32), .MUL_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .flush_i    (flush_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .stallreq_o (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op at the current (IDLE) negedge; returns at the negedge after DONE.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag, input bit hold);
      int lat;
      lat = op[1] ? 33 : 3;
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
      #1 check({tag, " stall_accept"}, 64'(stallreq_o), 64'd1);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         start_i = hold; op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
         #1;
         if (c < lat) begin
            check({tag, " ready_early"}, 64'(ready_o), 64'd0);
            check({tag, " stall_busy"}, 64'(stallreq_o), 64'd1);
         end else begin
            check({tag, " ready_done"}, 64'(ready_o), 64'd1);
            check({tag, " stall_done"}, 64'(stallreq_o), 64'd0);
            check({tag, " busy_done"}, 64'(busy_o), 64'd1);
            check({tag, " result"}, result_o, exp);
         end
      end
      @(negedge clk);
      check({tag, " ready_after"}, 64'(ready_o), 64'd0);
      check({tag, " busy_after"}, 64'(busy_o), 64'd0);
      check({tag, " result_hold"}, result_o, exp);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; start_i = 1'b0; op_i = 2'b00; opdata1_i = 32'd0; opdata2_i = 32'd0; flush_i = 1'b0;
      @(negedge clk); @(negedge clk);
      check("rst result", result_o, 64'd0);
      check("rst ready", 64'(ready_o), 64'd0);
      check("rst busy", 64'(busy_o), 64'd0);
      start_i = 1'b1;
      #1 check("rst stall_masked", 64'(stallreq_o), 64'd0);
      start_i = 1'b0; rst = 1'b0;
      @(negedge clk);

      do_op(OP_MULT,  32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, "mult_m1x2", 1'b0);
      do_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, "multu_ffx2", 1'b0);
      do_op(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, "mult_m3x5", 1'b0);
      do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, "div_m7d2", 1'b0);
      do_op(OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, "divu_100d7", 1'b0);
      do_op(OP_DIVU,  32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, "divu_by0", 1'b0);
      do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf", 1'b0);
      do_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7dm2", 1'b0);
      do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, "div_by0", 1'b0);

      // Flush a DIV in cycle 10, then accept a MULT in cycle 11.
      prev = 64'hFFFFFFF9_FFFFFFFF;
      start_i = 1'b1; op_i = OP_DIV; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      flush_i = 1'b1;
      #1 check("flush ready_c10", 64'(ready_o), 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      check("flush busy_c11", 64'(busy_o), 64'd0);
      check("flush ready_c11", 64'(ready_o), 64'd0);
      check("flush result_hold", result_o, prev);
      check("flush stall_idle", 64'(stallreq_o), 64'd0);
      do_op(OP_MULT, 32'h00000010, 32'h00000010, 64'h00000000_00000100, "mult_after_flush", 1'b0);

      // start_i held high across back-to-back operations.
      do_op(OP_MULT,  32'h00000003, 32'h00000004, 64'h00000000_0000000C, "b2b_mult", 1'b1);
      do_op(OP_DIVU,  32'd1000,     32'd10,       64'h00000000_00000064, "b2b_divu", 1'b1);
      do_op(OP_MULTU, 32'h80000000, 32'h00000004, 64'h00000002_00000000, "b2b_multu", 1'b1);
      do_op(OP_DIV,   32'hFFFFFF9C, 32'h00000007, 64'hFFFFFFFE_FFFFFFF2, "b2b_div", 1'b1);
      start_i = 1'b0;
      #1 check("b2b stall_release", 64'(stallreq_o), 64'd0);

      // Reset in cycle 5 of a DIV aborts it for good.
      @(negedge clk);
      start_i = 1'b1; op_i = OP_DIVU; opdata1_i = 32'd50; opdata2_i = 32'd5;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      #1;
      check("abort result", result_o, 64'd0);
      check("abort ready", 64'(ready_o), 64'd0);
      check("abort busy", 64'(busy_o), 64'd0);
      check("abort stall", 64'(stallreq_o), 64'd0);
      start_i = 1'b0; rst = 1'b0;
      hits = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_o !== 1'b0 || busy_o !== 1'b0) hits++;
      end
      check("abort no_resume", 64'(hits), 64'd0);
      check("abort result_zero", result_o, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
